// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: iterative binary-to-BCD converter (shift-add-3, one operand bit per clock).
// An optional two's-complement mode converts the magnitude and reports the sign separately.
//
// Parameters:
//   WIDTH       binary operand width in bits (>= 2)
//   DIGITS      number of BCD output digits (>= 1); too few digits is reported through OVF
//   SIGNED_MODE 1 = B_IN is two's complement, 0 = unsigned
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   START    in   conversion request, sampled only while idle
//   B_IN     in   binary operand, captured on the accepted START edge
//   BUSY     out  high while shifting and during the done cycle
//   DONE     out  one-cycle pulse when a result has been written
//   BCD_OUT  out  packed BCD result, digit 0 in [3:0], held between conversions
//   SIGN_OUT out  1 = negative operand (always 0 when SIGNED_MODE = 0)
//   OVF      out  1 = value did not fit in DIGITS digits (BCD_OUT holds value mod 10^DIGITS)
module bcd_seq_conv #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DIGITS      = 3,
    parameter bit          SIGNED_MODE = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [WIDTH-1:0]      B_IN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD_OUT,
    output logic                  SIGN_OUT,
    output logic                  OVF
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned AccW = 4 * DIGITS;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sign_q, sign_d;
    logic              sticky_q, sticky_d;
    logic [AccW-1:0]   bcd_q, bcd_d;
    logic              sign_out_q, sign_out_d;
    logic              ovf_q, ovf_d;

    logic [AccW-1:0]   acc_adj;
    logic [AccW-1:0]   acc_shift;
    logic              carry_out;
    logic              neg_in;

    // Add-3 correction on every digit >= 5 so the following doubling carries correctly.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // A 1 leaving the top digit is a carry worth 10^DIGITS: the result no longer fits.
    assign acc_shift = {acc_adj[AccW-2:0], opnd_q[WIDTH-1]};
    assign carry_out = acc_adj[AccW-1];

    assign neg_in = SIGNED_MODE && B_IN[WIDTH-1];

    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        sticky_d   = sticky_q;
        bcd_d      = bcd_q;
        sign_out_d = sign_out_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    // The most negative value negates to 2^(WIDTH-1), which is fine unsigned.
                    opnd_d   = neg_in ? (~B_IN + 1'b1) : B_IN;
                    sign_d   = neg_in;
                    acc_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = CntW'(WIDTH);
                    state_d  = StShift;
                end
            end
            StShift: begin
                acc_d    = acc_shift;
                opnd_d   = {opnd_q[WIDTH-2:0], 1'b0};
                sticky_d = sticky_q | carry_out;
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    // Publish the result of this final iteration on the same edge.
                    bcd_d      = acc_shift;
                    sign_out_d = sign_q;
                    ovf_d      = sticky_q | carry_out;
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            sticky_q   <= 1'b0;
            bcd_q      <= '0;
            sign_out_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            sticky_q   <= sticky_d;
            bcd_q      <= bcd_d;
            sign_out_q <= sign_out_d;
            ovf_q      <= ovf_d;
        end
    end

    assign BUSY     = (state_q != StIdle);
    assign DONE     = (state_q == StDone);
    assign BCD_OUT  = bcd_q;
    assign SIGN_OUT = sign_out_q;
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb_bcd_seq_conv: three converter configurations (8b/3d unsigned, 16b/4d unsigned,
// 8b/3d signed) driven by directed and random operands, compared against a decimal
// reference computed with division and modulo.
module tb_bcd_seq_conv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic [7:0]  b0 = '0;
    logic [15:0] b1 = '0;
    logic [7:0]  b2 = '0;

    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [11:0] bcd0;
    logic [15:0] bcd1;
    logic [11:0] bcd2;
    logic        sign0, sign1, sign2;
    logic        ovf0, ovf1, ovf2;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bcd_seq_conv #(.WIDTH(8), .DIGITS(3), .SIGNED_MODE(1'b0)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .START(start0), .B_IN(b0), .BUSY(busy0), .DONE(done0),
        .BCD_OUT(bcd0), .SIGN_OUT(sign0), .OVF(ovf0)
    );

    bcd_seq_conv #(.WIDTH(16), .DIGITS(4), .SIGNED_MODE(1'b0)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .B_IN(b1), .BUSY(busy1), .DONE(done1),
        .BCD_OUT(bcd1), .SIGN_OUT(sign1), .OVF(ovf1)
    );

    bcd_seq_conv #(.WIDTH(8), .DIGITS(3), .SIGNED_MODE(1'b1)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start2), .B_IN(b2), .BUSY(busy2), .DONE(done2),
        .BCD_OUT(bcd2), .SIGN_OUT(sign2), .OVF(ovf2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // what: 0 done, 1 busy, 2 bcd, 3 sign, 4 ovf
    function automatic logic [63:0] obs(input int sel, input int what);
        logic [63:0] r;
        r = '0;
        case (sel)
            0: case (what)
                0: r = 64'(done0); 1: r = 64'(busy0); 2: r = 64'(bcd0);
                3: r = 64'(sign0); default: r = 64'(ovf0);
            endcase
            1: case (what)
                0: r = 64'(done1); 1: r = 64'(busy1); 2: r = 64'(bcd1);
                3: r = 64'(sign1); default: r = 64'(ovf1);
            endcase
            default: case (what)
                0: r = 64'(done2); 1: r = 64'(busy2); 2: r = 64'(bcd2);
                3: r = 64'(sign2); default: r = 64'(ovf2);
            endcase
        endcase
        return r;
    endfunction

    task automatic drive(input int sel, input logic s, input logic [15:0] v);
        case (sel)
            0: begin start0 = s; b0 = v[7:0]; end
            1: begin start1 = s; b1 = v; end
            default: begin start2 = s; b2 = v[7:0]; end
        endcase
    endtask

    // Decimal digits of mag, least significant first, truncated to digits.
    function automatic logic [63:0] ref_bcd(input longint unsigned mag, input int digits);
        logic [63:0] r;
        longint unsigned m;
        r = '0;
        m = mag;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Called at a falling edge with the target converter idle. With poke set, START is
    // held high and B_IN scrambled for the whole busy period, including the done cycle.
    task automatic conv(input int sel, input logic [15:0] v, input bit poke);
        int              w, dg, n, bc;
        bit              sm, exp_sign;
        longint unsigned raw, mag, lim;
        logic [63:0]     exp_bcd;

        w  = (sel == 1) ? 16 : 8;
        dg = (sel == 1) ? 4 : 3;
        sm = (sel == 2);
        raw = longint'(v) & ((64'd1 << w) - 1);
        exp_sign = 1'b0;
        mag = raw;
        if (sm && raw >= (64'd1 << (w - 1))) begin
            mag = (64'd1 << w) - raw;
            exp_sign = 1'b1;
        end
        lim = 1;
        for (int i = 0; i < dg; i++) lim = lim * 10;
        exp_bcd = ref_bcd(mag, dg);

        drive(sel, 1'b1, v);
        @(negedge clk);
        drive(sel, poke, 16'($urandom));
        n = 0;
        bc = 0;
        while (n < 60) begin
            if (obs(sel, 1) == 64'd1) bc++;
            if (obs(sel, 0) == 64'd1) break;
            @(negedge clk);
            n++;
            if (poke) drive(sel, 1'b1, 16'($urandom));
        end
        check("latency", 64'(n), 64'(w));
        check("busy_cycles", 64'(bc), 64'(w + 1));
        check("bcd", obs(sel, 2), exp_bcd);
        check("sign", obs(sel, 3), 64'(exp_sign));
        check("ovf", obs(sel, 4), 64'(mag >= lim));
        if (!poke) drive(sel, 1'b0, 16'($urandom));
        @(negedge clk);
        check("done_pulse_end", obs(sel, 0), 64'd0);
        check("busy_end", obs(sel, 1), 64'd0);
        check("bcd_held", obs(sel, 2), exp_bcd);
        drive(sel, 1'b0, 16'($urandom));
    endtask

    task automatic quiet(input int sel, input int cycles);
        int hits;
        hits = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (obs(sel, 0) != 64'd0 || obs(sel, 1) != 64'd0) hits++;
        end
        check("quiet", 64'(hits), 64'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_done", 64'(done0), 64'd0);
        check("rst_bcd", 64'(bcd0), 64'd0);
        check("rst_ovf", 64'(ovf0), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned 8-bit: directed then random, back-to-back at minimum spacing.
        conv(0, 16'd255, 1'b0);
        conv(0, 16'd0, 1'b0);
        conv(0, 16'd99, 1'b1);
        quiet(0, 4);
        conv(0, 16'd200, 1'b1);
        quiet(0, 3);
        for (int i = 0; i < 8; i++) conv(0, 16'($urandom_range(0, 255)), 1'b0);

        // 16-bit operand into 4 digits: overflow boundary.
        conv(1, 16'hFFFF, 1'b0);
        conv(1, 16'd9999, 1'b0);
        conv(1, 16'd10000, 1'b0);
        conv(1, 16'd0, 1'b0);
        for (int i = 0; i < 6; i++) conv(1, 16'($urandom), 1'b0);

        // Signed 8-bit.
        conv(2, 16'h0080, 1'b0);
        conv(2, 16'h00FF, 1'b0);
        conv(2, 16'h007F, 1'b0);
        conv(2, 16'h0000, 1'b0);
        for (int i = 0; i < 6; i++) conv(2, 16'($urandom_range(0, 255)), 1'b0);

        // Mid-conversion asynchronous reset; the signed unit last held a negative result.
        conv(2, 16'h009C, 1'b0);
        drive(0, 1'b1, 16'd200);
        @(negedge clk);
        drive(0, 1'b0, 16'd0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy0), 64'd0);
        check("arst_done", 64'(done0), 64'd0);
        check("arst_bcd", 64'(bcd0), 64'd0);
        check("arst_bcd_s", 64'(bcd2), 64'd0);
        check("arst_sign_s", 64'(sign2), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet(0, 12);
        conv(0, 16'd42, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
